// File: rtl/stream_cipher_core_if.sv
// Handshake bundle for stream_cipher_core: key loading, input stream, output stream and status.
// master drives words and keys into the core; slave is the core itself.
interface stream_cipher_core_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  key_load;
   logic [DATA_WIDTH-1:0] key_in;
   logic                  mode;
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  rekey_req;
   logic [15:0]           word_count;

   modport master (
      output key_load, key_in, mode, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, rekey_req, word_count
   );

   modport slave (
      input  key_load, key_in, mode, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, rekey_req, word_count
   );
endinterface

// File: rtl/stream_cipher_core.sv
// Rolling-key XOR/rotate cipher with a Galois-LFSR key schedule, one-cycle latency,
// output backpressure and a word budget that stalls the stream until the next key load.
module stream_cipher_core #(
   parameter int                    DATA_WIDTH     = 8,
   parameter logic [DATA_WIDTH-1:0] TAPS           = DATA_WIDTH'(8'hB8),
   parameter int                    ROT            = 3,
   parameter int                    REKEY_INTERVAL = 16
) (
   input logic                  i_clk,
   input logic                  i_rst_n,
   stream_cipher_core_if.slave  io_bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_REKEY = 2'd2
   } state_t;

   localparam logic [15:0] LP_INTERVAL = 16'(REKEY_INTERVAL);

   state_t                r_state;
   state_t                w_state_next;
   logic [DATA_WIDTH-1:0] r_key;
   logic [DATA_WIDTH-1:0] r_out_data;
   logic                  r_out_valid;
   logic                  r_rekey_req;
   logic [15:0]           r_word_count;

   logic                  w_in_ready;
   logic                  w_accept;
   logic [15:0]           w_count_inc;
   logic [DATA_WIDTH-1:0] w_mix;
   logic [DATA_WIDTH-1:0] w_enc;
   logic [DATA_WIDTH-1:0] w_dec_rot;
   logic [DATA_WIDTH-1:0] w_result;
   logic [DATA_WIDTH-1:0] w_key_step;
   logic [DATA_WIDTH-1:0] w_key_seed;

   assign w_in_ready  = (r_state == ST_RUN) && (!r_out_valid || io_bus.out_ready);
   assign w_accept    = io_bus.in_valid && w_in_ready;
   assign w_count_inc = (r_word_count == 16'hFFFF) ? r_word_count : r_word_count + 16'd1;

   // Rotations are pure wiring: encrypt rotates left after XOR, decrypt undoes it first.
   assign w_mix = io_bus.in_data ^ r_key;
   genvar gi;
   generate
      for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_rot
         assign w_enc[(gi + ROT) % DATA_WIDTH] = w_mix[gi];
         assign w_dec_rot[gi]                  = io_bus.in_data[(gi + ROT) % DATA_WIDTH];
      end
   endgenerate

   assign w_result   = io_bus.mode ? (w_dec_rot ^ r_key) : w_enc;
   assign w_key_step = (r_key >> 1) ^ (r_key[0] ? TAPS : '0);
   // An all-zero key would freeze the LFSR, so it is replaced by 1.
   assign w_key_seed = (io_bus.key_in == '0) ? DATA_WIDTH'(1) : io_bus.key_in;

   always_comb begin
      w_state_next = r_state;
      if (io_bus.key_load) begin
         w_state_next = ST_RUN;
      end else if ((r_state == ST_RUN) && w_accept && (REKEY_INTERVAL != 0)
                   && (w_count_inc == LP_INTERVAL)) begin
         w_state_next = ST_REKEY;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_key        <= '0;
         r_out_data   <= '0;
         r_out_valid  <= 1'b0;
         r_rekey_req  <= 1'b0;
         r_word_count <= 16'd0;
      end else begin
         r_rekey_req <= (w_state_next == ST_REKEY);

         if (w_accept) begin
            r_out_data  <= w_result;
            r_out_valid <= 1'b1;
         end else if (io_bus.out_ready) begin
            r_out_valid <= 1'b0;
         end

         // A load in the same cycle as an accept wins: the word used the old key but is not counted.
         if (io_bus.key_load) begin
            r_key        <= w_key_seed;
            r_word_count <= 16'd0;
         end else if (w_accept) begin
            r_key        <= w_key_step;
            r_word_count <= w_count_inc;
         end
      end
   end

   assign io_bus.in_ready   = w_in_ready;
   assign io_bus.out_valid  = r_out_valid;
   assign io_bus.out_data   = r_out_data;
   assign io_bus.rekey_req  = r_rekey_req;
   assign io_bus.word_count = r_word_count;

endmodule

// File: tb/tb_stream_cipher_core.sv
// Randomised and directed bench for stream_cipher_core against a word-level reference model.
module tb_stream_cipher_core;
   localparam int          W        = 8;
   localparam logic [7:0]  TAPS     = 8'hB8;
   localparam int          ROT      = 3;
   localparam int          INTERVAL = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   stream_cipher_core_if #(.DATA_WIDTH(W)) bus();

   stream_cipher_core #(
      .DATA_WIDTH    (W),
      .TAPS          (TAPS),
      .ROT           (ROT),
      .REKEY_INTERVAL(INTERVAL)
   ) dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .io_bus (bus)
   );

   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: word-level state of the cipher
   bit m_loaded = 0;
   int m_key    = 0;
   int m_count  = 0;
   bit m_ov     = 0;
   int m_od     = 0;
   int exp_q[$];
   bit m_acc;
   int m_res;
   int m_front;

   function automatic int rotl(input int x, input int r);
      return ((x << r) | (x >> (W - r))) & 255;
   endfunction

   function automatic int enc(input int d, input int k);
      return rotl((d ^ k) & 255, ROT);
   endfunction

   function automatic int dec(input int d, input int k);
      return rotl(d, W - ROT) ^ k;
   endfunction

   function automatic int lfsr(input int k);
      return (k >> 1) ^ (((k & 1) != 0) ? int'(TAPS) : 0);
   endfunction

   function automatic bit m_rekey();
      return m_loaded && (m_count == INTERVAL);
   endfunction

   function automatic bit m_in_ready();
      return m_loaded && !m_rekey() && (!m_ov || bus.out_ready);
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            m_loaded = 0; m_key = 0; m_count = 0; m_ov = 0; m_od = 0;
            exp_q.delete();
         end else begin
            if (m_ov && bus.out_ready) begin
               check("sb_depth", (exp_q.size() > 0) ? 1 : 0, 1);
               if (exp_q.size() > 0) begin
                  m_front = exp_q.pop_front();
                  check("sb_word", int'(bus.out_data), m_front);
               end
            end
            m_acc = bus.in_valid && m_in_ready();
            if (m_acc) begin
               m_res = bus.mode ? dec(int'(bus.in_data), m_key) : enc(int'(bus.in_data), m_key);
               exp_q.push_back(m_res);
               m_ov = 1;
               m_od = m_res;
            end else if (bus.out_ready) begin
               m_ov = 0;
            end
            if (bus.key_load) begin
               m_key    = (bus.key_in == 0) ? 1 : int'(bus.key_in);
               m_count  = 0;
               m_loaded = 1;
            end else if (m_acc) begin
               m_key = lfsr(m_key);
               if (m_count < 65535) m_count++;
            end
         end
      end
   end

   // Cycle compare, sampled on the falling edge
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            check("in_ready",   int'(bus.in_ready),   int'(m_in_ready()));
            check("out_valid",  int'(bus.out_valid),  int'(m_ov));
            if (m_ov) check("out_data", int'(bus.out_data), m_od);
            check("rekey_req",  int'(bus.rekey_req),  int'(m_rekey()));
            check("word_count", int'(bus.word_count), m_count);
         end else begin
            check("rst_out_valid",  int'(bus.out_valid),  0);
            check("rst_out_data",   int'(bus.out_data),   0);
            check("rst_rekey_req",  int'(bus.rekey_req),  0);
            check("rst_word_count", int'(bus.word_count), 0);
            check("rst_in_ready",   int'(bus.in_ready),   0);
         end
      end
   end

   // All stimulus tasks start and end at posedge+1
   task automatic load_key(input logic [7:0] k);
      bus.key_load = 1'b1;
      bus.key_in   = k;
      @(posedge clk); #1;
      bus.key_load = 1'b0;
   endtask

   task automatic send(input logic [7:0] d, input logic m);
      int t;
      t = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.mode     = m;
      while (!bus.in_ready && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      check("send_ready", int'(bus.in_ready), 1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   logic [7:0] hold;

   initial begin
      bus.key_load  = 1'b0;
      bus.key_in    = '0;
      bus.mode      = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Data before any key load is never accepted
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h55;
      repeat (4) begin
         @(posedge clk); #1;
         check("no_key_ready", int'(bus.in_ready), 0);
      end
      bus.in_valid = 1'b0;

      // Encrypt and key advance
      load_key(8'h0D);
      send(8'h01, 1'b0);
      check("enc_0x01", int'(bus.out_data), 8'h60);
      check("key_adv_dut", int'(dut.r_key), 8'hBE);
      check("key_adv_model", m_key, 8'hBE);
      send(8'h0F, 1'b0);
      check("enc_0x0F", int'(bus.out_data), 8'h8D);

      // Decrypt round trip
      load_key(8'h0D);
      send(8'h60, 1'b1);
      check("dec_0x60", int'(bus.out_data), 8'h01);
      send(8'h8D, 1'b1);
      check("dec_0x8D", int'(bus.out_data), 8'h0F);

      // Zero key behaves as key 1
      load_key(8'h00);
      send(8'h01, 1'b0);
      check("zero_key_w0", int'(bus.out_data), 8'h00);
      send(8'h00, 1'b0);
      check("zero_key_w1", int'(bus.out_data), 8'hC5);

      // key_load together with an accept
      load_key(8'h0D);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h01;
      bus.mode     = 1'b0;
      bus.key_load = 1'b1;
      bus.key_in   = 8'h22;
      @(posedge clk); #1;
      bus.key_load = 1'b0;
      bus.in_valid = 1'b0;
      check("ld_acc_old_key", int'(bus.out_data), 8'h60);
      check("ld_acc_count", int'(bus.word_count), 0);
      send(8'h00, 1'b0);
      check("ld_acc_new_key", int'(bus.out_data), 8'h11);

      // Rekey stall after four words
      load_key(8'h3C);
      for (int i = 0; i < 4; i++) send(8'($urandom), 1'($urandom));
      check("rk_req", int'(bus.rekey_req), 1);
      check("rk_ready", int'(bus.in_ready), 0);
      check("rk_count", int'(bus.word_count), 4);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h01;
      bus.mode     = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         check("rk_stall_ready", int'(bus.in_ready), 0);
         check("rk_stall_req", int'(bus.rekey_req), 1);
      end
      bus.key_load = 1'b1;
      bus.key_in   = 8'h0D;
      @(posedge clk); #1;
      bus.key_load = 1'b0;
      check("rk_cleared", int'(bus.rekey_req), 0);
      check("rk_count_zero", int'(bus.word_count), 0);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check("rk_word5", int'(bus.out_data), 8'h60);
      check("rk_count_one", int'(bus.word_count), 1);
      send(8'($urandom), 1'b0);

      // Backpressure: one word captured, output held stable
      load_key(8'($urandom_range(1, 255)));
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'($urandom);
      @(posedge clk); #1;
      check("bp_captured", int'(bus.out_valid), 1);
      hold = bus.out_data;
      for (int i = 0; i < 3; i++) begin
         bus.in_data = 8'($urandom);
         @(posedge clk); #1;
         check("bp_ready", int'(bus.in_ready), 0);
         check("bp_stable", int'(bus.out_data), int'(hold));
      end
      bus.out_ready = 1'b1;
      send(8'($urandom), 1'b0);
      send(8'($urandom), 1'b1);

      // Random traffic with random key loads and backpressure
      for (int i = 0; i < 400; i++) begin
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.in_data   = 8'($urandom);
         bus.mode      = 1'($urandom);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         bus.key_load  = ($urandom_range(0, 9) == 0);
         bus.key_in    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         @(posedge clk); #1;
      end
      bus.key_load  = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;

      // Asynchronous reset while a word is pending
      load_key(8'h0D);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'h01;
      bus.mode      = 1'b0;
      @(posedge clk); #1;
      check("pre_rst_valid", int'(bus.out_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_out_valid", int'(bus.out_valid), 0);
      check("arst_out_data", int'(bus.out_data), 0);
      check("arst_in_ready", int'(bus.in_ready), 0);
      check("arst_word_count", int'(bus.word_count), 0);
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         check("post_rst_ready", int'(bus.in_ready), 0);
      end
      load_key(8'h0D);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check("post_rst_word", int'(bus.out_data), 8'h60);

      repeat (3) @(posedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
